clk_seq: RTL and testbench

CLK_SEQ -- requirements
Module: clk_seq

---
 rtl/clk_seq.sv | 196 +++++++++++++++++++
 tb/tb_clk_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_seq.sv
// Clock bring-up sequencer: waits for a stable clock-manager lock, starts the RAM
// clocks, then phase-aligned CPU/FPU clocks, then releases the CPU reset.
module clk_seq #(
   parameter int LOCK_WAIT   = 1024,
   parameter int RAM_LEAD    = 8,
   parameter int RESET_HOLD  = 16,
   parameter int LOSS_FILTER = 4
) (
   input  logic       FSBCLK,
   input  logic       nRST,
   input  logic       LOCKED,
   input  logic       CPUCLKr,
   input  logic       nRESREQ,
   output logic       RAMCLK_EN,
   output logic       CPUCLK_EN,
   output logic       nCPURES,
   output logic       READY,
   output logic [2:0] STATE
);

   localparam int MAXP = (LOCK_WAIT > RAM_LEAD) ? ((LOCK_WAIT > RESET_HOLD) ? LOCK_WAIT : RESET_HOLD)
                                                : ((RAM_LEAD > RESET_HOLD) ? RAM_LEAD : RESET_HOLD);
   localparam int CW = $clog2(MAXP + 1);
   localparam int FW = $clog2(LOSS_FILTER + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RAM_ON    = 3'd3,
      S_CPU_ON    = 3'd4,
      S_HOLD      = 3'd5,
      S_RUN       = 3'd6
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [FW-1:0] loss_cnt_q, loss_cnt_d;
   logic          lk_meta_q, lks_q;
   logic          loss_pend_q, loss_pend_d;
   logic          ram_en_q, ram_en_d;
   logic          cpu_en_q, cpu_en_d;
   logic          ncpures_q, ncpures_d;
   logic          ready_q, ready_d;
   logic          loss_det_s, active_s;

   // State, counters, lock synchronizer and registered outputs
   always_ff @(posedge FSBCLK or negedge nRST) begin
      if (!nRST) begin
         lk_meta_q   <= 1'b0;
         lks_q       <= 1'b0;
         state_q     <= S_IDLE;
         cnt_q       <= {CW{1'b0}};
         loss_cnt_q  <= {FW{1'b0}};
         loss_pend_q <= 1'b0;
         ram_en_q    <= 1'b0;
         cpu_en_q    <= 1'b0;
         ncpures_q   <= 1'b0;
         ready_q     <= 1'b0;
      end else begin
         lk_meta_q   <= LOCKED;
         lks_q       <= lk_meta_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         loss_cnt_q  <= loss_cnt_d;
         loss_pend_q <= loss_pend_d;
         ram_en_q    <= ram_en_d;
         cpu_en_q    <= cpu_en_d;
         ncpures_q   <= ncpures_d;
         ready_q     <= ready_d;
      end
   end

   // Next state, counters and next output values
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      loss_pend_d = 1'b0;
      ram_en_d    = 1'b0;
      cpu_en_d    = 1'b0;
      ncpures_d   = 1'b0;
      ready_d     = 1'b0;

      if (lks_q) begin
         loss_cnt_d = {FW{1'b0}};
      end else if (loss_cnt_q != FW'(LOSS_FILTER)) begin
         loss_cnt_d = loss_cnt_q + FW'(1);
      end else begin
         loss_cnt_d = loss_cnt_q;
      end
      loss_det_s = !lks_q && (loss_cnt_q == FW'(LOSS_FILTER - 1));
      active_s   = (state_q == S_RAM_ON) || (state_q == S_CPU_ON) ||
                   (state_q == S_HOLD)   || (state_q == S_RUN);

      // A detected loss first drops reset/READY, then the enables one cycle later
      if (loss_pend_q) begin
         state_d = S_WAIT_LOCK;
         cnt_d   = {CW{1'b0}};
      end else if (active_s && loss_det_s) begin
         loss_pend_d = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_WAIT_LOCK;
               cnt_d   = {CW{1'b0}};
            end
            S_WAIT_LOCK: begin
               if (lks_q) begin
                  state_d = S_STABLE;
                  cnt_d   = CW'(LOCK_WAIT - 1);
               end else begin
                  cnt_d   = {CW{1'b0}};
               end
            end
            S_STABLE: begin
               if (!lks_q) begin
                  state_d = S_WAIT_LOCK;
                  cnt_d   = {CW{1'b0}};
               end else if (cnt_q == {CW{1'b0}}) begin
                  state_d = S_RAM_ON;
                  cnt_d   = CW'(RAM_LEAD - 1);
               end else begin
                  cnt_d   = cnt_q - CW'(1);
               end
            end
            S_RAM_ON: begin
               if (cnt_q == {CW{1'b0}}) begin
                  state_d = S_CPU_ON;
               end else begin
                  cnt_d   = cnt_q - CW'(1);
               end
            end
            S_CPU_ON: begin
               if (CPUCLKr) begin
                  state_d = S_HOLD;
                  cnt_d   = CW'(RESET_HOLD - 1);
               end else begin
                  state_d = S_CPU_ON;
               end
            end
            S_HOLD: begin
               if (!nRESREQ) begin
                  cnt_d   = CW'(RESET_HOLD - 1);
               end else if (CPUCLKr) begin
                  if (cnt_q == {CW{1'b0}}) begin
                     state_d = S_RUN;
                  end else begin
                     cnt_d   = cnt_q - CW'(1);
                  end
               end else begin
                  state_d = S_HOLD;
               end
            end
            S_RUN: begin
               if (!nRESREQ) begin
                  state_d = S_HOLD;
                  cnt_d   = CW'(RESET_HOLD - 1);
               end else begin
                  state_d = S_RUN;
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = {CW{1'b0}};
            end
         endcase
      end

      if (loss_pend_d) begin
         ram_en_d = ram_en_q;
         cpu_en_d = cpu_en_q;
      end else begin
         case (state_d)
            S_RAM_ON, S_CPU_ON: ram_en_d = 1'b1;
            S_HOLD: begin
               ram_en_d = 1'b1;
               cpu_en_d = 1'b1;
            end
            S_RUN: begin
               ram_en_d  = 1'b1;
               cpu_en_d  = 1'b1;
               ncpures_d = 1'b1;
               ready_d   = 1'b1;
            end
            default: ram_en_d = 1'b0;
         endcase
      end
   end

   assign RAMCLK_EN = ram_en_q;
   assign CPUCLK_EN = cpu_en_q;
   assign nCPURES   = ncpures_q;
   assign READY     = ready_q;
   assign STATE     = state_q;

endmodule

// File: tb/tb_clk_seq.sv
// Directed bench for clk_seq: expected values are queued when stimulus is applied
// and popped when the matching DUT response is sampled.
module tb_clk_seq;

   localparam int LW = 1024;
   localparam int RL = 8;
   localparam int RH = 16;
   localparam int LF = 4;

   localparam logic [6:0] M_RAM  = 7'b1000000;
   localparam logic [6:0] M_CPU  = 7'b0100000;
   localparam logic [6:0] M_NRES = 7'b0010000;
   localparam logic [6:0] M_ST   = 7'b0000111;
   localparam logic [6:0] V_RAM  = 7'b1000011;
   localparam logic [6:0] V_HOLD = 7'b1100101;
   localparam logic [6:0] V_RUN  = 7'b1111110;
   localparam logic [6:0] V_LOSS = 7'b1100110;
   localparam logic [6:0] V_WAIT = 7'b0000001;

   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic       locked = 1'b0;
   logic       cpuclkr = 1'b0;
   logic       nresreq = 1'b1;
   logic       ramclk_en, cpuclk_en, ncpures, ready;
   logic [2:0] state;
   logic [6:0] vec;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   exp_t exp_q[$];

   int checks = 0;
   int fails  = 0;

   assign vec = {ramclk_en, cpuclk_en, ncpures, ready, state};

   clk_seq #(.LOCK_WAIT(LW), .RAM_LEAD(RL), .RESET_HOLD(RH), .LOSS_FILTER(LF)) dut (
      .FSBCLK(clk), .nRST(nrst), .LOCKED(locked), .CPUCLKr(cpuclkr), .nRESREQ(nresreq),
      .RAMCLK_EN(ramclk_en), .CPUCLK_EN(cpuclk_en), .nCPURES(ncpures), .READY(ready), .STATE(state)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(negedge clk);
         cpuclkr = ~cpuclkr;
      end
   end

   task automatic push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         fails++;
         $error("FAIL scoreboard_empty: observed %0h with nothing expected", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e.val) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic wait_vec(input string tag, input logic [6:0] mask, input logic [6:0] val,
                           input int bound, output int n);
      bit found;
      found = 1'b0;
      n = 0;
      while (!found && n < bound) begin
         @(posedge clk);
         #1;
         n++;
         if ((vec & mask) === val) found = 1'b1;
      end
      checks++;
      assert (found) else begin
         fails++;
         $error("FAIL %s: timeout after %0d cycles, observed %0h expected %0h", tag, n, vec & mask, val);
      end
   endtask

   initial begin
      int n;
      int ph;
      bit bad;

      // reset state
      push("reset_vec", 32'd0);
      repeat (3) @(posedge clk);
      #1;
      pop_chk({25'd0, vec});

      // full bring-up with lock present from release
      @(negedge clk);
      locked = 1'b1;
      nrst   = 1'b1;
      push("ram_latency", LW + 3);
      push("ram_on_vec", {25'd0, V_RAM});
      push("ram_lead", RL);
      push("cpu_phase", 32'd1);
      push("hold_vec", {25'd0, V_HOLD});
      push("hold_cycles", 2 * RH);
      push("run_vec", {25'd0, V_RUN});
      wait_vec("wait_ram", M_RAM, M_RAM, LW + 20, n);
      pop_chk(n);
      pop_chk({25'd0, vec});
      wait_vec("wait_cpu_on", M_ST, 7'd4, RL + 5, n);
      pop_chk(n);
      wait_vec("wait_cpu_en", M_CPU, M_CPU, 10, n);
      pop_chk({31'd0, cpuclkr});
      pop_chk({25'd0, vec});
      wait_vec("wait_run", M_NRES, M_NRES, 4 * RH, n);
      pop_chk(n);
      pop_chk({25'd0, vec});

      // three-cycle lock dropout is filtered
      @(negedge clk);
      locked = 1'b0;
      repeat (3) @(negedge clk);
      locked = 1'b1;
      for (int i = 0; i < 10; i++) begin
         push("glitch3_run", {25'd0, V_RUN});
         @(posedge clk);
         #1;
         pop_chk({25'd0, vec});
      end

      // sustained loss: reset/READY first, enables one cycle later
      @(negedge clk);
      locked = 1'b0;
      push("loss_latency", LF + 2);
      push("loss_vec", {25'd0, V_LOSS});
      push("loss_next_vec", {25'd0, V_WAIT});
      wait_vec("wait_loss", M_NRES, 7'd0, 20, n);
      pop_chk(n);
      pop_chk({25'd0, vec});
      @(posedge clk);
      #1;
      pop_chk({25'd0, vec});

      // relock, then asynchronous reset while in HOLD
      @(negedge clk);
      locked = 1'b1;
      wait_vec("wait_hold", M_ST, 7'd5, LW + 100, n);
      #2;
      nrst = 1'b0;
      push("async_reset_vec", 32'd0);
      push("reset_held_vec", 32'd0);
      #1;
      pop_chk({25'd0, vec});
      @(posedge clk);
      #1;
      pop_chk({25'd0, vec});

      // lock dropout at STABLE count 500 restarts the full lock wait
      @(negedge clk);
      nrst = 1'b1;
      wait_vec("wait_stable", M_ST, 7'd2, 10, n);
      repeat (LW - 1 - 500) @(posedge clk);
      @(negedge clk);
      locked = 1'b0;
      repeat (2) @(negedge clk);
      locked = 1'b1;
      push("drop_to_wait", 32'd1);
      push("drop_ram_off", 32'd0);
      push("restart_full_count", LW);
      push("rerun_vec", {25'd0, V_RUN});
      wait_vec("wait_relock_wait", M_ST, 7'd1, 10, n);
      pop_chk({29'd0, state});
      pop_chk({31'd0, ramclk_en});
      wait_vec("wait_restable", M_ST, 7'd2, 10, n);
      wait_vec("wait_ram2", M_RAM, M_RAM, LW + 20, n);
      pop_chk(n);
      wait_vec("wait_run2", M_NRES, M_NRES, 4 * RH + RL + 10, n);
      pop_chk({25'd0, vec});

      // CPU reset request: held reload, then RESET_HOLD CPU periods
      @(negedge clk);
      nresreq = 1'b0;
      push("resreq_low_vec", 32'd0);
      push("resreq_periods", RH);
      push("resreq_cpu_en_stayed", 32'd0);
      push("resreq_run_vec", {25'd0, V_RUN});
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (ncpures !== 1'b0 || cpuclk_en !== 1'b1 || state !== 3'd5) bad = 1'b1;
      end
      pop_chk({31'd0, bad});
      @(negedge clk);
      nresreq = 1'b1;
      ph = 0;
      bad = 1'b0;
      for (int i = 0; i < 4 * RH && ncpures !== 1'b1; i++) begin
         @(posedge clk);
         #1;
         if (cpuclkr === 1'b1) ph++;
         if (cpuclk_en !== 1'b1) bad = 1'b1;
      end
      pop_chk(ph);
      pop_chk({31'd0, bad});
      pop_chk({25'd0, vec});

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
